// File: rtl/hh_sched_pkg.sv
// Shared types and defaults for the heavy_hash job scheduler.
package hh_sched_pkg;

  // Header words per job when the instantiating level does not override it
  localparam int HH_HDR_WORDS_DEF = 10;

  typedef enum logic [1:0] {
    D_IDLE,
    D_SEL,
    D_HDR,
    D_NONCE
  } disp_state_t;

  typedef enum logic {
    C_IDLE,
    C_OUT
  } coll_state_t;

endpackage

// File: rtl/hh_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
// The caller owns the pointer and advances it past the granted index.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  logic [N-1:0] upper;
  logic [N-1:0] cand;

  // Prefer requesters at or above the pointer, otherwise wrap to the lowest index
  always_comb begin
    upper = '0;
    for (int j = 0; j < N; j++) begin
      upper[j] = req[j] && (W'(j) >= ptr);
    end
    cand    = (|upper) ? upper : req;
    gnt     = '0;
    gnt_idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (cand[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = W'(j);
      end
    end
  end

  assign gnt_valid = |req;

endmodule

// File: rtl/hh_sched.sv
// Heavy_hash job scheduler: feeds whole jobs (header words + nonce) to one
// core at a time and drains per-core results into a single result register.
// Optional build macro HH_SCHED_TARGET_CMP_EN: results whose hash exceeds
// target are read from the core and dropped instead of being emitted.
//
// Dispatch FSM
//   state   | meaning
//   D_IDLE  | waiting for job_valid
//   D_SEL   | choosing a core with room in both hashin and nonce FIFOs
//   D_HDR   | streaming header words into the selected core
//   D_NONCE | writing the captured nonce, then counting the job
// Collect FSM
//   state   | meaning
//   C_IDLE  | result register empty, reading the next non-empty core
//   C_OUT   | result held on res_* until res_ready
module hh_sched
  import hh_sched_pkg::*;
#(
  parameter int NCORES    = 4,
  parameter int HDR_WORDS = HH_HDR_WORDS_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [63:0]                 job_data,
  input  logic [31:0]                 job_nonce,
  output logic [NCORES-1:0]           core_hashin_we,
  output logic [63:0]                 core_hashin_din,
  input  logic [NCORES-1:0]           core_hashin_full,
  output logic [NCORES-1:0]           core_nonce_we,
  output logic [31:0]                 core_nonce_din,
  input  logic [NCORES-1:0]           core_nonce_full,
  input  logic [NCORES-1:0]           core_hashout_empty,
  output logic [NCORES-1:0]           core_hashout_re,
  input  logic [NCORES*256-1:0]       core_hashout_dout,
  input  logic [NCORES*32-1:0]        core_nonce_out,
  input  logic [255:0]                target,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [255:0]                res_hash,
  output logic [31:0]                 res_nonce,
  output logic [$clog2(NCORES)-1:0]   res_core,
  output logic [31:0]                 job_cnt,
  output logic [31:0]                 res_cnt,
  output logic                        sched_idle
);

  localparam int CW = $clog2(NCORES);
  localparam int WW = $clog2(HDR_WORDS + 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(HDR_WORDS - 1);
  localparam logic [CW-1:0] LAST_CORE = CW'(NCORES - 1);

  disp_state_t       d_state;
  logic [CW-1:0]     d_ptr;
  logic [CW-1:0]     d_sel;
  logic [WW-1:0]     word_cnt;
  logic [31:0]       nonce_hold;
  logic [NCORES-1:0] d_req;
  logic [NCORES-1:0] d_gnt_unused;
  logic [CW-1:0]     d_gnt_idx;
  logic              d_gnt_valid;
  logic              hdr_acc;
  logic              nonce_wr;

  coll_state_t       c_state;
  logic [CW-1:0]     c_ptr;
  logic [NCORES-1:0] c_gnt;
  logic [CW-1:0]     c_gnt_idx;
  logic              c_gnt_valid;
  logic              c_rd;
  logic              keep;
  logic [255:0]      hash_mux;
  logic [31:0]       nonce_mux;

  // A core is only eligible when it can take both the header and the nonce,
  // so a chosen job never has to move mid-stream
  assign d_req = ~core_hashin_full & ~core_nonce_full;

  rr_arbiter #(.N(NCORES)) u_disp_arb (
    .req       (d_req),
    .ptr       (d_ptr),
    .gnt       (d_gnt_unused),
    .gnt_idx   (d_gnt_idx),
    .gnt_valid (d_gnt_valid)
  );

  rr_arbiter #(.N(NCORES)) u_coll_arb (
    .req       (~core_hashout_empty),
    .ptr       (c_ptr),
    .gnt       (c_gnt),
    .gnt_idx   (c_gnt_idx),
    .gnt_valid (c_gnt_valid)
  );

  assign job_ready       = (d_state == D_HDR) && !core_hashin_full[d_sel];
  assign hdr_acc         = job_valid && job_ready;
  assign nonce_wr        = (d_state == D_NONCE) && !core_nonce_full[d_sel];
  assign c_rd            = (c_state == C_IDLE) && c_gnt_valid;
  assign core_hashin_din = job_data;
  assign core_nonce_din  = nonce_hold;
  assign sched_idle      = (d_state == D_IDLE) && (c_state == C_IDLE) && (&core_hashout_empty);

  // One-hot write/read strobes, qualified by the owning FSM state
  always_comb begin
    core_hashin_we  = '0;
    core_nonce_we   = '0;
    core_hashout_re = '0;
    if (hdr_acc)  core_hashin_we[d_sel] = 1'b1;
    if (nonce_wr) core_nonce_we[d_sel]  = 1'b1;
    if (c_rd)     core_hashout_re       = c_gnt;
  end

  // Select the granted core's head hash and nonce
  always_comb begin
    hash_mux  = '0;
    nonce_mux = '0;
    for (int j = 0; j < NCORES; j++) begin
      if (c_gnt[j]) begin
        hash_mux  = core_hashout_dout[j*256 +: 256];
        nonce_mux = core_nonce_out[j*32 +: 32];
      end
    end
  end

`ifdef HH_SCHED_TARGET_CMP_EN
  assign keep = (hash_mux <= target);
`else
  logic unused_target;
  assign unused_target = ^target;
  assign keep = 1'b1;
`endif

  // Dispatch FSM: select a core, stream the header, then write the nonce
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state    <= D_IDLE;
      d_ptr      <= '0;
      d_sel      <= '0;
      word_cnt   <= '0;
      nonce_hold <= '0;
      job_cnt    <= '0;
    end else begin
      case (d_state)
        D_IDLE: begin
          if (job_valid) d_state <= D_SEL;
        end
        D_SEL: begin
          if (d_gnt_valid) begin
            d_sel    <= d_gnt_idx;
            d_ptr    <= (d_gnt_idx == LAST_CORE) ? '0 : d_gnt_idx + 1'b1;
            word_cnt <= '0;
            d_state  <= D_HDR;
          end
        end
        D_HDR: begin
          if (hdr_acc) begin
            if (word_cnt == '0) nonce_hold <= job_nonce;
            if (word_cnt == LAST_WORD) begin
              word_cnt <= '0;
              d_state  <= D_NONCE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        D_NONCE: begin
          if (nonce_wr) begin
            job_cnt <= job_cnt + 32'd1;
            d_state <= D_IDLE;
          end
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end

  // Collect FSM: read one core result into the output register and hold it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_state   <= C_IDLE;
      c_ptr     <= '0;
      res_valid <= 1'b0;
      res_hash  <= '0;
      res_nonce <= '0;
      res_core  <= '0;
      res_cnt   <= '0;
    end else begin
      case (c_state)
        C_IDLE: begin
          if (c_rd) begin
            c_ptr <= (c_gnt_idx == LAST_CORE) ? '0 : c_gnt_idx + 1'b1;
            if (keep) begin
              res_hash  <= hash_mux;
              res_nonce <= nonce_mux;
              res_core  <= c_gnt_idx;
              res_valid <= 1'b1;
              c_state   <= C_OUT;
            end
          end
        end
        C_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_cnt   <= res_cnt + 32'd1;
            c_state   <= C_IDLE;
          end
        end
        default: c_state <= C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hh_sched.sv
`timescale 1ns/1ps
module tb_hh_sched;

  localparam int NC = 4;
  localparam int HW = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             job_valid = 1'b0;
  logic             job_ready;
  logic [63:0]      job_data = '0;
  logic [31:0]      job_nonce = '0;
  logic [NC-1:0]    core_hashin_we;
  logic [63:0]      core_hashin_din;
  logic [NC-1:0]    core_hashin_full = '0;
  logic [NC-1:0]    core_nonce_we;
  logic [31:0]      core_nonce_din;
  logic [NC-1:0]    core_nonce_full = '0;
  logic [NC-1:0]    hout_empty = '1;
  logic [NC-1:0]    core_hashout_re;
  logic [NC*256-1:0] dout_flat;
  logic [NC*32-1:0] nout_flat;
  logic [255:0]     target = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [255:0]     res_hash;
  logic [31:0]      res_nonce;
  logic [1:0]       res_core;
  logic [31:0]      job_cnt;
  logic [31:0]      res_cnt;
  logic             sched_idle;

  logic [255:0]     hout_hash [NC];
  logic [31:0]      hout_nonce [NC];

  always #5 clk = ~clk;

  always_comb begin
    dout_flat = '0;
    nout_flat = '0;
    for (int k = 0; k < NC; k++) begin
      dout_flat[k*256 +: 256] = hout_hash[k];
      nout_flat[k*32 +: 32]   = hout_nonce[k];
    end
  end

  hh_sched #(.NCORES(NC), .HDR_WORDS(HW)) dut (
    .clk                (clk),
    .rst                (rst),
    .job_valid          (job_valid),
    .job_ready          (job_ready),
    .job_data           (job_data),
    .job_nonce          (job_nonce),
    .core_hashin_we     (core_hashin_we),
    .core_hashin_din    (core_hashin_din),
    .core_hashin_full   (core_hashin_full),
    .core_nonce_we      (core_nonce_we),
    .core_nonce_din     (core_nonce_din),
    .core_nonce_full    (core_nonce_full),
    .core_hashout_empty (hout_empty),
    .core_hashout_re    (core_hashout_re),
    .core_hashout_dout  (dout_flat),
    .core_nonce_out     (nout_flat),
    .target             (target),
    .res_valid          (res_valid),
    .res_ready          (res_ready),
    .res_hash           (res_hash),
    .res_nonce          (res_nonce),
    .res_core           (res_core),
    .job_cnt            (job_cnt),
    .res_cnt            (res_cnt),
    .sched_idle         (sched_idle)
  );

  typedef struct { int core; logic [63:0] data; } hin_t;
  typedef struct { int core; logic [31:0] nonce; } non_t;
  typedef struct { int core; bit emit; } rd_t;
  typedef struct { int core; logic [255:0] hash; logic [31:0] nonce; } res_t;
  typedef struct {
    bit           rst_first;
    logic [3:0]   hfull;
    logic [31:0]  nonce;
    logic [63:0]  base;
    int           core;
    int           stall_after;
    int           nfull_cyc;
    int           abort_at;
    int           exp_cnt;
  } job_t;

  hin_t hin_q[$];
  non_t non_q[$];
  rd_t  rd_q[$];
  res_t res_q[$];
  job_t jobs [7];

  int   nvec = 0;
  int   nerr = 0;
  bit   acc_seen, ready_samp;
  bit   pend_valid = 1'b0;
  bit   pend_emit;
  int   pend_core;
  logic [NC-1:0] re_seen;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [255:0] act);
    nvec++;
    nerr++;
    $display("FAIL %s: got strobe %0h, expected none", name, act);
  endtask

  task automatic monitor();
    logic [NC-1:0] oh;
    hin_t h;
    non_t n;
    rd_t  r;
    res_t e;
    acc_seen   = job_valid && job_ready;
    ready_samp = job_ready;
    re_seen    = core_hashout_re;
    chk("hashin_we_onehot", 256'($onehot0(core_hashin_we)), 1);
    chk("nonce_we_onehot", 256'($onehot0(core_nonce_we)), 1);
    chk("hashout_re_onehot", 256'($onehot0(core_hashout_re)), 1);
    if (pend_valid) begin
      chk("res_latency_valid", res_valid, pend_emit);
      if (pend_emit) chk("res_latency_core", res_core, pend_core);
      pend_valid = 1'b0;
    end
    if (core_hashin_we != '0) begin
      if (hin_q.size() == 0) fail_unexp("hashin_unexpected", core_hashin_we);
      else begin
        h = hin_q.pop_front();
        oh = '0; oh[h.core] = 1'b1;
        chk("hashin_we", core_hashin_we, oh);
        chk("hashin_din", core_hashin_din, h.data);
      end
    end
    if (core_nonce_we != '0) begin
      if (non_q.size() == 0) fail_unexp("nonce_unexpected", core_nonce_we);
      else begin
        n = non_q.pop_front();
        oh = '0; oh[n.core] = 1'b1;
        chk("nonce_we", core_nonce_we, oh);
        chk("nonce_din", core_nonce_din, n.nonce);
      end
    end
    if (core_hashout_re != '0) begin
      if (rd_q.size() == 0) fail_unexp("read_unexpected", core_hashout_re);
      else begin
        r = rd_q.pop_front();
        oh = '0; oh[r.core] = 1'b1;
        chk("hashout_re", core_hashout_re, oh);
        pend_valid = 1'b1;
        pend_emit  = r.emit;
        pend_core  = r.core;
      end
    end
    if (res_valid && res_ready) begin
      if (res_q.size() == 0) fail_unexp("result_unexpected", res_hash);
      else begin
        e = res_q.pop_front();
        chk("res_core", res_core, e.core);
        chk("res_hash", res_hash, e.hash);
        chk("res_nonce", res_nonce, e.nonce);
      end
    end
  endtask

  // One clock: sample at negedge, then let the core result FIFOs pop after the edge
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    hout_empty = hout_empty | re_seen;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    job_valid = 1'b0;
    core_hashin_full = '0;
    core_nonce_full = '0;
    hout_empty = '1;
    res_ready = 1'b0;
    hin_q.delete(); non_q.delete(); rd_q.delete(); res_q.delete();
    pend_valid = 1'b0;
    step();
    step();
    chk("rst_job_ready", job_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_job_cnt", job_cnt, 0);
    chk("rst_res_cnt", res_cnt, 0);
    chk("rst_res_hash", res_hash, 0);
    chk("rst_res_nonce", res_nonce, 0);
    chk("rst_res_core", res_core, 0);
    chk("rst_strobes", {core_hashin_we, core_nonce_we, core_hashout_re}, 0);
    rst = 1'b0;
    step();
    chk("rst_sched_idle", sched_idle, 1);
  endtask

  task automatic send_job(input job_t j);
    int w, g;
    bit first, stalled;
    logic [63:0] wd;
    core_hashin_full = j.hfull;
    core_nonce_full = '0;
    non_q.push_back('{j.core, j.nonce});
    w = 0; g = 0; first = 1'b1; stalled = 1'b0;
    job_nonce = j.nonce;
    job_data = j.base;
    job_valid = 1'b1;
    hin_q.push_back('{j.core, j.base});
    while (w < HW && g < 200) begin
      if (j.abort_at >= 0 && w == j.abort_at + 1) begin
        rst = 1'b1;
        step();
        chk("abort_hashin_we", core_hashin_we, 0);
        chk("abort_nonce_we", core_nonce_we, 0);
        chk("abort_job_ready", job_ready, 0);
        chk("abort_job_cnt", job_cnt, 0);
        job_valid = 1'b0;
        hin_q.delete(); non_q.delete();
        rst = 1'b0;
        step();
        return;
      end
      if (j.stall_after >= 0 && w == j.stall_after + 1 && !stalled) begin
        stalled = 1'b1;
        core_hashin_full[j.core] = 1'b1;
        repeat (3) begin
          step();
          chk("stall_job_ready", job_ready, 0);
          chk("stall_hashin_we", core_hashin_we, 0);
        end
        core_hashin_full[j.core] = 1'b0;
      end
      step();
      g++;
      if (first) begin
        chk("ready_low_in_idle", ready_samp, 0);
        first = 1'b0;
      end
      if (acc_seen) begin
        w++;
        if (w < HW) begin
          wd = j.base + 64'(w);
          job_data = wd;
          hin_q.push_back('{j.core, wd});
        end else begin
          job_valid = 1'b0;
        end
      end
    end
    chk("header_timeout", w, HW);
    if (j.nfull_cyc > 0) begin
      core_nonce_full[j.core] = 1'b1;
      repeat (j.nfull_cyc) begin
        step();
        chk("nonce_full_we", core_nonce_we, 0);
      end
      core_nonce_full[j.core] = 1'b0;
    end
    g = 0;
    while (non_q.size() != 0 && g < 20) begin
      step();
      g++;
    end
    chk("nonce_timeout", non_q.size(), 0);
    chk("job_cnt", job_cnt, j.exp_cnt);
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((rd_q.size() != 0 || res_q.size() != 0 || pend_valid) && g < 40) begin
      step();
      g++;
    end
    chk(name, rd_q.size() + res_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] h0, h1, h2, h3, t255;
    int exp_rc;

    for (int k = 0; k < NC; k++) begin
      hout_hash[k]  = '0;
      hout_nonce[k] = '0;
    end

    //          rst hfull    nonce          base                    core stall nful abort cnt
    jobs[0] = '{0, 4'b0000, 32'hA000_0001, 64'h1111_0000_0000_0000, 0, -1, 0, -1, 1};
    jobs[1] = '{0, 4'b0000, 32'hA000_0002, 64'h2222_0000_0000_0000, 1, -1, 2, -1, 2};
    jobs[2] = '{0, 4'b0000, 32'hA000_0003, 64'h3333_0000_0000_0000, 2, -1, 0, -1, 3};
    jobs[3] = '{1, 4'b0010, 32'hB000_0001, 64'h4444_0000_0000_0000, 0,  4, 0, -1, 1};
    jobs[4] = '{0, 4'b0010, 32'hB000_0002, 64'h5555_0000_0000_0000, 2, -1, 0, -1, 2};
    jobs[5] = '{0, 4'b0000, 32'hC000_0001, 64'h6666_0000_0000_0000, 3, -1, 0,  5, 0};
    jobs[6] = '{0, 4'b0000, 32'hC000_0002, 64'h7777_0000_0000_0000, 0, -1, 0, -1, 1};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (jobs[i].rst_first) do_reset();
      send_job(jobs[i]);
    end

    // Two ready cores, consumer always ready
    do_reset();
    res_ready = 1'b1;
    h1 = {8{32'h1111_C0DE}};
    h3 = {8{32'h3333_C0DE}};
    hout_hash[1] = h1; hout_nonce[1] = 32'hD000_0001;
    hout_hash[3] = h3; hout_nonce[3] = 32'hD000_0003;
    rd_q.push_back('{1, 1'b1});
    rd_q.push_back('{3, 1'b1});
    res_q.push_back('{1, h1, 32'hD000_0001});
    res_q.push_back('{3, h3, 32'hD000_0003});
    hout_empty = 4'b0101;
    drain("drain_two_cores");
    chk("res_cnt_two", res_cnt, 2);
    chk("idle_after_drain", sched_idle, 1);

    // Consumer stalls for 20 cycles with a result pending
    do_reset();
    h0 = {8{32'h0000_BEEF}};
    h2 = {8{32'h2222_BEEF}};
    hout_hash[0] = h0; hout_nonce[0] = 32'hE000_0000;
    hout_hash[2] = h2; hout_nonce[2] = 32'hE000_0002;
    rd_q.push_back('{0, 1'b1});
    rd_q.push_back('{2, 1'b1});
    res_q.push_back('{0, h0, 32'hE000_0000});
    res_q.push_back('{2, h2, 32'hE000_0002});
    hout_empty = 4'b1010;
    step();
    repeat (20) begin
      step();
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_hash", res_hash, h0);
      chk("hold_res_nonce", res_nonce, 32'hE000_0000);
      chk("hold_res_core", res_core, 0);
      chk("hold_no_read", core_hashout_re, 0);
    end
    chk("busy_not_idle", sched_idle, 0);
    res_ready = 1'b1;
    drain("drain_after_hold");
    chk("res_cnt_hold", res_cnt, 2);

    // Target comparison: below, above and equal to target
    do_reset();
    res_ready = 1'b1;
    t255 = '0; t255[255] = 1'b1;
    target = t255;
    h0 = '0; h0[254] = 1'b1;
    h1 = t255; h1[0] = 1'b1;
    h2 = t255;
    hout_hash[0] = h0; hout_nonce[0] = 32'hF000_0000;
    hout_hash[1] = h1; hout_nonce[1] = 32'hF000_0001;
    hout_hash[2] = h2; hout_nonce[2] = 32'hF000_0002;
`ifdef HH_SCHED_TARGET_CMP_EN
    rd_q.push_back('{0, 1'b1});
    rd_q.push_back('{1, 1'b0});
    rd_q.push_back('{2, 1'b1});
    res_q.push_back('{0, h0, 32'hF000_0000});
    res_q.push_back('{2, h2, 32'hF000_0002});
    exp_rc = 2;
`else
    rd_q.push_back('{0, 1'b1});
    rd_q.push_back('{1, 1'b1});
    rd_q.push_back('{2, 1'b1});
    res_q.push_back('{0, h0, 32'hF000_0000});
    res_q.push_back('{1, h1, 32'hF000_0001});
    res_q.push_back('{2, h2, 32'hF000_0002});
    exp_rc = 3;
`endif
    hout_empty = 4'b1000;
    drain("drain_target");
    chk("res_cnt_target", res_cnt, exp_rc);
    step();
    chk("target_no_stray_valid", res_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
